mul53_mp_pipe: RTL

Pipelined, handshaked multi-precision multiplier: the successor to the combinational 53-bit radix-4 Booth partial-product array.
- Accepts one operand pair per cycle.
- Performs one full-width product, two packed 24-bit products (single precision) or four packed 11-bit products (half precision), selected per transaction.
- Resolves the carry-save pair internally and returns a final product with zeroed guard fields and per-lane zero flags.
- Feeds the FMA alignment/add stage and supports backpressure from it.

---
 rtl/mul53_mp_pipe.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mul53_mp_pipe.sv
// Pipelined multi-precision multiplier: one full-width, two 24-bit or four 11-bit
// unsigned products per transaction, built from radix-4 Booth terms, a carry-save array and a final add.
module mul53_mp_pipe #(
    parameter int WIDTH  = 53,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [1:0]           out_mode,
    output logic [TAG_W-1:0]     out_tag,
    output logic [3:0]           lane_zero
);

    localparam int PW      = 2 * WIDTH;
    localparam int MID     = STAGES - 2;
    localparam int ND_FULL = WIDTH / 2 + 1;
    localparam int ND_DUAL = 13;
    localparam int ND_QUAD = 6;

    function automatic logic [WIDTH-1:0] op_mask(input logic [1:0] m);
        logic [WIDTH-1:0] r;
        r = '0;
        case (m)
            2'b10:   begin r[23:0] = '1; r[52:29] = '1; end
            2'b01:   begin r[10:0] = '1; r[24:14] = '1; r[38:28] = '1; r[52:42] = '1; end
            default: r = '1;
        endcase
        return r;
    endfunction

    function automatic logic [PW-1:0] prod_mask(input logic [1:0] m);
        logic [PW-1:0] r;
        r = '0;
        case (m)
            2'b10:   begin r[47:0] = '1; r[105:58] = '1; end
            2'b01:   begin r[21:0] = '1; r[49:28] = '1; r[77:56] = '1; r[105:84] = '1; end
            default: r = '1;
        endcase
        return r;
    endfunction

    // Adds every Booth term of a*b (shifted by 'shift') into the sum/carry pair.
    // A negative term is the inverted magnitude; its +1 rides in the free carry LSB.
    function automatic logic [2*PW-1:0] booth_acc(
        input logic [2*PW-1:0] sc,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input int               nd,
        input int               shift
    );
        logic [PW-1:0]    s, c, m, pp, mj;
        logic [WIDTH+5:0] bx;
        logic [2:0]       trip;
        logic             neg;
        s  = sc[2*PW-1:PW];
        c  = sc[PW-1:0];
        bx = {5'b0, b, 1'b0};
        for (int i = 0; i < nd; i++) begin
            trip = bx[2*i +: 3];
            case (trip)
                3'b001, 3'b010: begin m = PW'(a);         neg = 1'b0; end
                3'b011:         begin m = PW'(a) << 1;    neg = 1'b0; end
                3'b100:         begin m = PW'(a) << 1;    neg = 1'b1; end
                3'b101, 3'b110: begin m = PW'(a);         neg = 1'b1; end
                default:        begin m = '0;             neg = 1'b0; end
            endcase
            pp = m << (2 * i + shift);
            if (neg) pp = ~pp;
            mj = (s & c) | (s & pp) | (c & pp);
            s  = s ^ c ^ pp;
            c  = {mj[PW-2:0], neg};
        end
        return {s, c};
    endfunction

    logic [STAGES:1] v, rdy, ld;

    always_comb begin : ready_chain
        logic r;
        r = !v[STAGES] || out_ready;
        rdy[STAGES] = r;
        for (int k = STAGES - 1; k >= 1; k--) begin
            r = !v[k] || r;
            rdy[k] = r;
        end
    end

    always_comb begin
        ld[1] = rdy[1] && in_valid;
        for (int k = 2; k <= STAGES; k++) ld[k] = rdy[k] && v[k-1];
    end

    assign in_ready  = rdy[1];
    assign out_valid = v[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else begin
            if (rdy[1]) v[1] <= in_valid;
            for (int k = 2; k <= STAGES; k++) begin
                if (rdy[k]) v[k] <= v[k-1];
            end
        end
    end

    logic [WIDTH-1:0] a1, b1;
    logic [1:0]       mode1;
    logic [TAG_W-1:0] tag1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1    <= '0;
            b1    <= '0;
            mode1 <= '0;
            tag1  <= '0;
        end else if (ld[1]) begin
            a1    <= multiplicand & op_mask(mode);
            b1    <= multiplier & op_mask(mode);
            mode1 <= mode;
            tag1  <= in_tag;
        end
    end

    // Packed lanes get their own Booth rows so no cross-lane terms are ever formed.
    logic [2*PW-1:0] sc;
    logic [PW-1:0]   booth_s, booth_c;

    always_comb begin
        sc = '0;
        case (mode1)
            2'b10: begin
                sc = booth_acc(sc, WIDTH'(a1[23:0]),  WIDTH'(b1[23:0]),  ND_DUAL, 0);
                sc = booth_acc(sc, WIDTH'(a1[52:29]), WIDTH'(b1[52:29]), ND_DUAL, 58);
            end
            2'b01: begin
                sc = booth_acc(sc, WIDTH'(a1[10:0]),  WIDTH'(b1[10:0]),  ND_QUAD, 0);
                sc = booth_acc(sc, WIDTH'(a1[24:14]), WIDTH'(b1[24:14]), ND_QUAD, 28);
                sc = booth_acc(sc, WIDTH'(a1[38:28]), WIDTH'(b1[38:28]), ND_QUAD, 56);
                sc = booth_acc(sc, WIDTH'(a1[52:42]), WIDTH'(b1[52:42]), ND_QUAD, 84);
            end
            default: sc = booth_acc(sc, a1, b1, ND_FULL, 0);
        endcase
        booth_s = sc[2*PW-1:PW];
        booth_c = sc[PW-1:0];
    end

    logic [PW-1:0]    fin_s, fin_c;
    logic [1:0]       fin_mode;
    logic [TAG_W-1:0] fin_tag;

    generate
        if (MID > 0) begin : g_mid
            logic [PW-1:0]    s_r [MID];
            logic [PW-1:0]    c_r [MID];
            logic [1:0]       m_r [MID];
            logic [TAG_W-1:0] t_r [MID];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < MID; j++) begin
                        s_r[j] <= '0;
                        c_r[j] <= '0;
                        m_r[j] <= '0;
                        t_r[j] <= '0;
                    end
                end else begin
                    if (ld[2]) begin
                        s_r[0] <= booth_s;
                        c_r[0] <= booth_c;
                        m_r[0] <= mode1;
                        t_r[0] <= tag1;
                    end
                    for (int j = 1; j < MID; j++) begin
                        if (ld[j+2]) begin
                            s_r[j] <= s_r[j-1];
                            c_r[j] <= c_r[j-1];
                            m_r[j] <= m_r[j-1];
                            t_r[j] <= t_r[j-1];
                        end
                    end
                end
            end

            assign fin_s    = s_r[MID-1];
            assign fin_c    = c_r[MID-1];
            assign fin_mode = m_r[MID-1];
            assign fin_tag  = t_r[MID-1];
        end else begin : g_nomid
            assign fin_s    = booth_s;
            assign fin_c    = booth_c;
            assign fin_mode = mode1;
            assign fin_tag  = tag1;
        end
    endgenerate

    logic [PW-1:0] fin_prod;
    logic [3:0]    fin_lz;

    always_comb begin
        fin_prod = (fin_s + fin_c) & prod_mask(fin_mode);
        case (fin_mode)
            2'b10:   fin_lz = {2'b00, fin_prod[105:58] == '0, fin_prod[47:0] == '0};
            2'b01:   fin_lz = {fin_prod[105:84] == '0, fin_prod[77:56] == '0,
                               fin_prod[49:28] == '0, fin_prod[21:0] == '0};
            default: fin_lz = {3'b000, fin_prod == '0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product   <= '0;
            out_mode  <= '0;
            out_tag   <= '0;
            lane_zero <= '0;
        end else if (ld[STAGES]) begin
            product   <= fin_prod;
            out_mode  <= fin_mode;
            out_tag   <= fin_tag;
            lane_zero <= fin_lz;
        end
    end

endmodule
